mac_tx_arb: RTL and testbench

MAC_TX_ARB -- requirements
Module: mac_tx_arb

---
 rtl/mac_tx_arb.sv | 150 +++++++++++++++
 tb/tb_mac_tx_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arb.sv
// Round-robin frame arbiter in front of a MAC transmit port: a grant is held
// for a whole frame, and an optional inter-packet gap follows each frame.
module mac_tx_arb #(
  parameter int  DATA_W  = 16,
  parameter int  REQ_N   = 2,
  parameter int  IPG_CYC = 3,
  localparam int LEN_W   = $clog2(DATA_W/8+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REQ_N-1:0]        valid_i,
  input  logic [REQ_N-1:0]        start_i,
  input  logic [REQ_N-1:0]        term_i,
  input  logic [REQ_N*DATA_W-1:0] data_i,
  input  logic [REQ_N*LEN_W-1:0]  len_i,
  output logic [REQ_N-1:0]        ready_o,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic                    start_o,
  output logic                    term_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [LEN_W-1:0]        len_o,
  output logic [REQ_N-1:0]        grant_o,
  output logic                    err_o
);

  localparam int         PTR_W    = (REQ_N > 2) ? 2 : 1;
  localparam logic [3:0] GAP_LOAD = (IPG_CYC > 0) ? 4'(IPG_CYC - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_PASS = 3'b010,
    ST_GAP  = 3'b100
  } state_t;

  state_t             state_q, state_d;
  logic [REQ_N-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q,  gidx_d;
  logic [PTR_W-1:0]   rr_q,    rr_d;
  logic [3:0]         gap_q,   gap_d;
  logic               mid_q,   mid_d;

  logic [REQ_N-1:0]   req;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               xfer;
  int                 cand;

  assign req = valid_i & start_i;

  // First requester at or after rr_q, wrapping modulo REQ_N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = 0; i < REQ_N; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= REQ_N) cand = cand - REQ_N;
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default here so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    mid_d   = mid_q;
    ready_o = '0;
    valid_o = 1'b0;
    start_o = 1'b0;
    term_o  = 1'b0;
    data_o  = '0;
    len_o   = '0;
    err_o   = 1'b0;
    xfer    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Stray mid-frame beats are swallowed and flagged; no beat moves
        // during the grant decision.
        ready_o = valid_i & ~start_i;
        err_o   = |(valid_i & ~start_i);
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          mid_d             = 1'b0;
          state_d           = ST_PASS;
        end
      end

      ST_PASS: begin
        valid_o         = valid_i[gidx_q];
        start_o         = start_i[gidx_q];
        term_o          = term_i[gidx_q];
        data_o          = data_i[int'(gidx_q)*DATA_W +: DATA_W];
        len_o           = len_i[int'(gidx_q)*LEN_W +: LEN_W];
        ready_o[gidx_q] = ready_i;
        xfer            = valid_i[gidx_q] & ready_i;
        if (xfer) begin
          mid_d = 1'b1;
          err_o = start_i[gidx_q] & mid_q;
          if (term_i[gidx_q]) begin
            rr_d    = (int'(gidx_q) == REQ_N - 1) ? '0 : gidx_q + 1'b1;
            grant_d = '0;
            gap_d   = GAP_LOAD;
            state_d = (IPG_CYC > 0) ? ST_GAP : ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_o = (state_q == ST_PASS) ? grant_q : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      mid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      mid_q   <= mid_d;
    end
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Scoreboard bench for mac_tx_arb: directed frames push expected MAC beats,
// a negedge monitor pops and compares on every MAC-side transfer.
module tb_mac_tx_arb;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      valid_i, start_i, term_i;
  logic [N*DW-1:0]   data_i;
  logic [N*LW-1:0]   len_i;
  logic              ready_i;

  logic [N-1:0]      ready_a, grant_a, ready_b, grant_b;
  logic              valid_a, start_a, term_a, err_a;
  logic              valid_b, start_b, term_b, err_b;
  logic [DW-1:0]     data_a, data_b;
  logic [LW-1:0]     len_a, len_b;

  logic              use_b = 1'b0;
  logic [N-1:0]      m_ready, m_grant;
  logic              m_valid, m_start, m_term, m_err;
  logic [DW-1:0]     m_data;
  logic [LW-1:0]     m_len;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LW-1:0] len;
    logic          start;
    logic          term;
    logic [N-1:0]  grant;
    logic          err;
  } beat_t;

  beat_t sb_q[$];
  beat_t mon_act, mon_exp;
  int    n_pass  = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  mac_tx_arb #(.DATA_W(DW), .REQ_N(N), .IPG_CYC(2)) u_dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .start_i(start_i),
    .term_i(term_i), .data_i(data_i), .len_i(len_i), .ready_o(ready_a),
    .ready_i(ready_i), .valid_o(valid_a), .start_o(start_a), .term_o(term_a),
    .data_o(data_a), .len_o(len_a), .grant_o(grant_a), .err_o(err_a)
  );

  mac_tx_arb #(.DATA_W(DW), .REQ_N(N), .IPG_CYC(0)) u_dut_nogap (
    .clk(clk), .reset(reset), .valid_i(valid_i), .start_i(start_i),
    .term_i(term_i), .data_i(data_i), .len_i(len_i), .ready_o(ready_b),
    .ready_i(ready_i), .valid_o(valid_b), .start_o(start_b), .term_o(term_b),
    .data_o(data_b), .len_o(len_b), .grant_o(grant_b), .err_o(err_b)
  );

  assign m_ready = use_b ? ready_b : ready_a;
  assign m_grant = use_b ? grant_b : grant_a;
  assign m_valid = use_b ? valid_b : valid_a;
  assign m_start = use_b ? start_b : start_a;
  assign m_term  = use_b ? term_b  : term_a;
  assign m_err   = use_b ? err_b   : err_a;
  assign m_data  = use_b ? data_b  : data_a;
  assign m_len   = use_b ? len_b   : len_a;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic s,
                      input logic t, input logic [N-1:0] g, input logic e);
    beat_t b;
    b = {d, l, s, t, g, e};
    sb_q.push_back(b);
  endtask

  // Check grant/ready in the current cycle, then advance one cycle.
  task automatic obs(input string nm, input logic [N-1:0] g, input logic [N-1:0] r);
    @(negedge clk);
    check({nm, "_grant"}, 64'(m_grant), 64'(g));
    check({nm, "_ready"}, 64'(m_ready), 64'(r));
    step();
  endtask

  // Source-side driver: holds each beat until it is accepted.
  task automatic drive_frame(input int k, input int nb, input logic [DW-1:0] base,
                             input int dup, input logic [LW-1:0] lenlast);
    int t;
    for (int b = 0; b < nb; b++) begin
      valid_i[k]           = 1'b1;
      start_i[k]           = (b == 0) || (b == dup);
      term_i[k]            = (b == nb - 1);
      data_i[k*DW +: DW]   = base + DW'(b);
      len_i[k*LW +: LW]    = (b == nb - 1) ? lenlast : LW'(2);
      for (t = 0; t < 60; t++) begin
        @(negedge clk);
        if (m_ready[k]) break;
      end
      if (t == 60) begin
        n_total++;
        $display("FAIL drive_timeout src%0d beat%0d: got no ready in 60 cycles, expected ready", k, b);
        valid_i[k] = 1'b0; start_i[k] = 1'b0; term_i[k] = 1'b0;
        return;
      end
      step();
    end
    valid_i[k] = 1'b0;
    start_i[k] = 1'b0;
    term_i[k]  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (m_valid === 1'b1 && ready_i === 1'b1) begin
      mon_act = {m_data, m_len, m_start, m_term, m_grant, m_err};
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got beat %0h, expected no beat", mon_act);
      end else begin
        mon_exp = sb_q.pop_front();
        check("sb_beat", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] s1_tab [11];
    logic [N-1:0] s5_tab [5];
    s1_tab = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    s5_tab = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    reset = 1'b1; valid_i = '0; start_i = '0; term_i = '0;
    data_i = '0; len_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_grant", 64'(m_grant), 64'(0));
    check("rst_err",   64'(m_err),   64'(0));
    step();
    reset = 1'b0;

    // Both sources request together: source 0 first, source 1 after the gap.
    push(16'h1000, 2'd2, 1'b1, 1'b0, 2'b01, 1'b0);
    push(16'h1001, 2'd2, 1'b0, 1'b0, 2'b01, 1'b0);
    push(16'h1002, 2'd1, 1'b0, 1'b1, 2'b01, 1'b0);
    push(16'h2000, 2'd2, 1'b1, 1'b0, 2'b10, 1'b0);
    push(16'h2001, 2'd1, 1'b0, 1'b1, 2'b10, 1'b0);
    fork
      drive_frame(0, 3, 16'h1000, -1, 2'd1);
      drive_frame(1, 2, 16'h2000, -1, 2'd1);
      for (int c = 0; c < 11; c++) obs($sformatf("s1_c%0d", c), s1_tab[c], s1_tab[c]);
    join
    repeat (2) step();

    // rr_ptr back at 0: source 0 wins again; MAC stalls 4 cycles mid-frame.
    for (int b = 0; b < 5; b++)
      push(16'h3000 + 16'(b), 2'(b == 4 ? 1 : 2), b == 0, b == 4, 2'b01, 1'b0);
    push(16'h4000, 2'd2, 1'b1, 1'b1, 2'b10, 1'b0);
    fork
      drive_frame(0, 5, 16'h3000, -1, 2'd1);
      drive_frame(1, 1, 16'h4000, -1, 2'd2);
      begin
        step();
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_data",  64'(m_data),  64'(16'h3001));
          check("stall_valid", 64'(m_valid), 64'(1));
          check("stall_ready", 64'(m_ready), 64'(0));
          step();
        end
        ready_i = 1'b1;
      end
    join
    repeat (4) step();

    // Non-start beat in IDLE: accepted, dropped, one-cycle error.
    valid_i[1] = 1'b1; start_i[1] = 1'b0; data_i[DW +: DW] = 16'h5555;
    @(negedge clk);
    check("idle_err",   64'(m_err),   64'(1));
    check("idle_ready", 64'(m_ready), 64'(2'b10));
    check("idle_valid", 64'(m_valid), 64'(0));
    check("idle_grant", 64'(m_grant), 64'(0));
    step();
    valid_i[1] = 1'b0;
    @(negedge clk);
    check("idle_err_end", 64'(m_err),   64'(0));
    check("idle_grant2",  64'(m_grant), 64'(0));
    step();

    // Repeated start on beat 2 of a 4-beat frame.
    push(16'h6000, 2'd2, 1'b1, 1'b0, 2'b01, 1'b0);
    push(16'h6001, 2'd2, 1'b0, 1'b0, 2'b01, 1'b0);
    push(16'h6002, 2'd2, 1'b1, 1'b0, 2'b01, 1'b1);
    push(16'h6003, 2'd3, 1'b0, 1'b1, 2'b01, 1'b0);
    drive_frame(0, 4, 16'h6000, 2, 2'd3);
    repeat (4) step();

    // Move rr_ptr to 1, then abort a source-1 frame with reset.
    push(16'h7000, 2'd2, 1'b1, 1'b1, 2'b01, 1'b0);
    drive_frame(0, 1, 16'h7000, -1, 2'd2);
    repeat (4) step();
    push(16'h8000, 2'd2, 1'b1, 1'b0, 2'b10, 1'b0);
    push(16'h8001, 2'd2, 1'b0, 1'b0, 2'b10, 1'b0);
    valid_i[1] = 1'b1; start_i[1] = 1'b1; term_i[1] = 1'b0;
    data_i[DW +: DW] = 16'h8000; len_i[LW +: LW] = 2'd2;
    obs("rst_c0", 2'b00, 2'b00);
    step();
    start_i[1] = 1'b0; data_i[DW +: DW] = 16'h8001;
    reset = 1'b1;
    step();
    valid_i = '0; start_i = '0; term_i = '0; data_i = '0; len_i = '0;
    @(negedge clk);
    check("abort_valid", 64'(m_valid), 64'(0));
    check("abort_grant", 64'(m_grant), 64'(0));
    check("abort_ready", 64'(m_ready), 64'(0));
    check("abort_data",  64'(m_data),  64'(0));
    check("abort_err",   64'(m_err),   64'(0));
    step();
    reset = 1'b0;
    push(16'h9000, 2'd2, 1'b1, 1'b1, 2'b01, 1'b0);
    push(16'h9100, 2'd2, 1'b1, 1'b1, 2'b10, 1'b0);
    fork
      drive_frame(0, 1, 16'h9000, -1, 2'd2);
      drive_frame(1, 1, 16'h9100, -1, 2'd2);
    join
    repeat (6) step();

    // Zero-gap instance: single-beat frames back to back.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    use_b = 1'b1;
    push(16'hA000, 2'd2, 1'b1, 1'b1, 2'b01, 1'b0);
    push(16'hB000, 2'd2, 1'b1, 1'b1, 2'b10, 1'b0);
    fork
      drive_frame(0, 1, 16'hA000, -1, 2'd2);
      drive_frame(1, 1, 16'hB000, -1, 2'd2);
      for (int c = 0; c < 5; c++) obs($sformatf("s5_c%0d", c), s5_tab[c], s5_tab[c]);
    join
    repeat (2) step();

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
